// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: keypad-driven combination lock sequencer.
// Converts the scanner's ping/key_code into one debounced key event per
// physical press, then runs code entry, check, unlock, reprogramming and
// failed-attempt lockout over those events.
//
// Handshake note: there is no valid/ready pairing on this block. The only
// internal transfer is key_strobe (valid, one cycle) carrying key_last; the
// lock FSM is always ready and consumes it on the cycle after it is raised,
// except in CHECK and LOCKOUT, or when a timer expires in the same cycle,
// where the event is dropped.
module combo_lock_ctrl #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1_000_000,
  parameter logic [31:0] HOLD_CYCLES     = 32'd500_000,
  parameter logic [2:0]  MAX_FAILS       = 3'd3,
  parameter logic [31:0] LOCKOUT_CYCLES  = 32'd3_000_000_000,
  parameter logic [31:0] RELOCK_CYCLES   = 32'd1_000_000_000,
  parameter logic [15:0] DEFAULT_CODE    = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       ping,
  output logic       unlocked,
  output logic       alarm,
  output logic       error,
  output logic       key_strobe,
  output logic [3:0] key_last,
  output logic [2:0] digit_count
);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_CHECK    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_PROGRAM  = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_t;

  // Lock FSM state; kept as a named enum so checkers can bind to it.
  state_t      state;

  logic [31:0] hold_cnt;
  logic        held;
  logic [31:0] db_cnt;
  logic        db;

  logic [15:0] entry_buf;
  logic        over;
  logic [15:0] code;
  logic [2:0]  fails;
  logic [31:0] tmr;

  logic        is_digit;
  logic        key_enter;
  logic        key_clear;
  logic        key_prog;
  logic        entry_ok;
  logic        code_match;
  logic [2:0]  fails_inc;
  logic [15:0] buf_shift;

  // A key counts as held while a ping was seen within the last HOLD_CYCLES.
  assign held = (hold_cnt != 32'd0);

  // Key class decode of the captured key value.
  assign is_digit  = (key_last <= 4'd9);
  assign key_enter = (key_last == 4'hE);
  assign key_clear = (key_last == 4'hF);
  assign key_prog  = (key_last == 4'hA);

  // Entry is acceptable only with exactly four digits and no overflow.
  assign entry_ok   = (digit_count == 3'd4) && !over;
  assign code_match = entry_ok && (entry_buf == code);

  // Failure count saturates at MAX_FAILS rather than wrapping.
  assign fails_inc = (fails >= MAX_FAILS) ? MAX_FAILS : fails + 3'd1;

  // New digit shifts in at the low nibble; first digit ends up in [15:12].
  assign buf_shift = {entry_buf[11:0], key_last};

  // Hold detector: reload on ping, drain otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 32'd0;
    end else if (ping) begin
      hold_cnt <= HOLD_CYCLES;
    end else if (hold_cnt != 32'd0) begin
      hold_cnt <= hold_cnt - 32'd1;
    end
  end

  // Debounce: db follows held only after DEBOUNCE_CYCLES of disagreement;
  // a rising db emits the key event and captures the key value.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt     <= 32'd0;
      db         <= 1'b0;
      key_strobe <= 1'b0;
      key_last   <= 4'd0;
    end else begin
      key_strobe <= 1'b0;
      if (held == db) begin
        db_cnt <= 32'd0;
      end else if (db_cnt == DEBOUNCE_CYCLES - 32'd1) begin
        db     <= held;
        db_cnt <= 32'd0;
        if (held) begin
          key_strobe <= 1'b1;
          key_last   <= key_code;
        end
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end
    end
  end

  // Lock FSM with entry buffer, stored code, fail count, shared timer and
  // registered status outputs (updated on the same edge as the state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOCKED;
      code        <= DEFAULT_CODE;
      entry_buf   <= 16'd0;
      digit_count <= 3'd0;
      over        <= 1'b0;
      fails       <= 3'd0;
      tmr         <= 32'd0;
      unlocked    <= 1'b0;
      alarm       <= 1'b0;
      error       <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state)
        S_LOCKED: begin
          if (key_strobe) begin
            if (is_digit) begin
              if (digit_count != 3'd4) begin
                entry_buf   <= buf_shift;
                digit_count <= digit_count + 3'd1;
              end else begin
                over <= 1'b1;
              end
            end else if (key_clear) begin
              entry_buf   <= 16'd0;
              digit_count <= 3'd0;
              over        <= 1'b0;
            end else if (key_enter) begin
              state <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          // Single-cycle decision; the buffer is cleared on every outcome.
          entry_buf   <= 16'd0;
          digit_count <= 3'd0;
          over        <= 1'b0;
          tmr         <= 32'd0;
          if (code_match) begin
            state    <= S_UNLOCKED;
            unlocked <= 1'b1;
            fails    <= 3'd0;
          end else begin
            error <= 1'b1;
            fails <= fails_inc;
            if (fails_inc == MAX_FAILS) begin
              state <= S_LOCKOUT;
              alarm <= 1'b1;
            end else begin
              state <= S_LOCKED;
            end
          end
        end

        S_UNLOCKED: begin
          // Relock expiry takes priority over a coincident key event.
          if (tmr == RELOCK_CYCLES - 32'd1) begin
            state    <= S_LOCKED;
            unlocked <= 1'b0;
            tmr      <= 32'd0;
          end else if (key_strobe) begin
            tmr <= 32'd0;
            if (key_prog) begin
              state       <= S_PROGRAM;
              entry_buf   <= 16'd0;
              digit_count <= 3'd0;
              over        <= 1'b0;
            end else if (key_enter || key_clear) begin
              state    <= S_LOCKED;
              unlocked <= 1'b0;
            end
          end else begin
            tmr <= tmr + 32'd1;
          end
        end

        S_PROGRAM: begin
          // Relock timer is held at zero while reprogramming.
          tmr <= 32'd0;
          if (key_strobe) begin
            if (is_digit) begin
              if (digit_count != 3'd4) begin
                entry_buf   <= buf_shift;
                digit_count <= digit_count + 3'd1;
              end else begin
                over <= 1'b1;
              end
            end else if (key_enter) begin
              entry_buf   <= 16'd0;
              digit_count <= 3'd0;
              over        <= 1'b0;
              if (entry_ok) begin
                code  <= entry_buf;
                state <= S_UNLOCKED;
              end else begin
                error <= 1'b1;
              end
            end else if (key_clear) begin
              entry_buf   <= 16'd0;
              digit_count <= 3'd0;
              over        <= 1'b0;
              state       <= S_UNLOCKED;
            end
          end
        end

        S_LOCKOUT: begin
          // Key events are ignored until the lockout period elapses.
          if (tmr == LOCKOUT_CYCLES - 32'd1) begin
            state <= S_LOCKED;
            alarm <= 1'b0;
            fails <= 3'd0;
            tmr   <= 32'd0;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end

        default: begin
          state    <= S_LOCKED;
          unlocked <= 1'b0;
          alarm    <= 1'b0;
          tmr      <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb_combo_lock_ctrl: directed and randomized key-press stimulus for
// combo_lock_ctrl, checked against a key-level behavioural lock model.
module tb_combo_lock_ctrl;

  localparam int MAXF        = 3;
  localparam int LOCKOUT_LEN = 50;
  localparam int RELOCK_LEN  = 100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_code;
  logic       ping;
  logic       unlocked;
  logic       alarm;
  logic       error;
  logic       key_strobe;
  logic [3:0] key_last;
  logic [2:0] digit_count;

  always #5 clk = ~clk;

  combo_lock_ctrl #(
    .DEBOUNCE_CYCLES(32'd4),
    .HOLD_CYCLES    (32'd8),
    .MAX_FAILS      (3'd3),
    .LOCKOUT_CYCLES (32'd50),
    .RELOCK_CYCLES  (32'd100),
    .DEFAULT_CODE   (16'h1234)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_code   (key_code),
    .ping       (ping),
    .unlocked   (unlocked),
    .alarm      (alarm),
    .error      (error),
    .key_strobe (key_strobe),
    .key_last   (key_last),
    .digit_count(digit_count)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- output activity counters ----------------
  int n_strobe = 0;
  int n_err    = 0;
  int n_alarm  = 0;
  int n_unl    = 0;

  always begin
    @(posedge clk);
    #1;
    if (key_strobe === 1'b1) n_strobe++;
    if (error === 1'b1)      n_err++;
    if (alarm === 1'b1)      n_alarm++;
    if (unlocked === 1'b1)   n_unl++;
  end

  // ---------------- reference model (key-level) ----------------
  typedef enum {M_LOCKED, M_UNLOCKED, M_PROGRAM} mstate_t;
  mstate_t m_st;
  int      m_code[4];
  int      m_q[$];
  bit      m_over;
  int      m_fails;

  task automatic model_reset();
    m_st    = M_LOCKED;
    m_code  = '{1, 2, 3, 4};
    m_q.delete();
    m_over  = 1'b0;
    m_fails = 0;
  endtask

  task automatic model_clear();
    m_q.delete();
    m_over = 1'b0;
  endtask

  task automatic model_digit(input int k);
    if (m_q.size() < 4) m_q.push_back(k);
    else m_over = 1'b1;
  endtask

  // Apply one key event; report expected error pulses and alarm cycles.
  task automatic model_key(input int k, output int e_err, output int e_alarm);
    bit ok;
    e_err   = 0;
    e_alarm = 0;
    case (m_st)
      M_LOCKED: begin
        if (k <= 9) model_digit(k);
        else if (k == 15) model_clear();
        else if (k == 14) begin
          ok = (m_q.size() == 4) && !m_over;
          if (ok) for (int i = 0; i < 4; i++) if (m_q[i] != m_code[i]) ok = 1'b0;
          if (ok) begin
            m_st    = M_UNLOCKED;
            m_fails = 0;
          end else begin
            e_err = 1;
            if (m_fails < MAXF) m_fails++;
            if (m_fails == MAXF) begin
              e_alarm = LOCKOUT_LEN;
              m_fails = 0;
            end
          end
          model_clear();
        end
      end
      M_UNLOCKED: begin
        if (k == 10) begin
          m_st = M_PROGRAM;
          model_clear();
        end else if (k == 14 || k == 15) m_st = M_LOCKED;
      end
      M_PROGRAM: begin
        if (k <= 9) model_digit(k);
        else if (k == 14) begin
          if (m_q.size() == 4 && !m_over) begin
            for (int i = 0; i < 4; i++) m_code[i] = m_q[i];
            m_st = M_UNLOCKED;
          end else e_err = 1;
          model_clear();
        end else if (k == 15) begin
          m_st = M_UNLOCKED;
          model_clear();
        end
      end
      default: m_st = M_LOCKED;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One press: ping 1 cycle in 4 for `active` cycles, then `idle` quiet cycles.
  task automatic press(input int k, input int active, input int idle);
    key_code = 4'(k);
    for (int i = 0; i < active + idle; i++) begin
      @(negedge clk);
      ping = (i < active) && (i % 4 == 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    ping = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_unlocked",    32'(unlocked),    32'd0);
    check("rst_alarm",       32'(alarm),       32'd0);
    check("rst_error",       32'(error),       32'd0);
    check("rst_key_strobe",  32'(key_strobe),  32'd0);
    check("rst_key_last",    32'(key_last),    32'd0);
    check("rst_digit_count", 32'(digit_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_press(input int k);
    int s_str, s_err, s_alm, e_err, e_alm;
    s_str = n_strobe;
    s_err = n_err;
    s_alm = n_alarm;
    model_key(k, e_err, e_alm);
    press(k, 40, 20);
    check("strobe_count",  32'(n_strobe - s_str), 32'd1);
    check("key_last",      32'(key_last),         32'(k));
    check("error_pulses",  32'(n_err - s_err),    32'(e_err));
    check("alarm_cycles",  32'(n_alarm - s_alm),  32'(e_alm));
    check("unlocked",      32'(unlocked),         32'(m_st != M_LOCKED));
    check("alarm_after",   32'(alarm),            32'd0);
    check("digit_count",   32'(digit_count),      32'(m_q.size()));
  endtask

  // Keys packed as hex nibbles, first key in the most significant used nibble.
  task automatic seq(input logic [31:0] ks, input int n);
    logic [31:0] v;
    v = ks;
    for (int i = 0; i < n; i++) check_press(int'(v[4*(n-1-i) +: 4]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s_unl, r, k;
    rst      = 1'b1;
    ping     = 1'b0;
    key_code = 4'd0;
    model_reset();

    // Reset state, then a single debounced press.
    do_reset();
    check_press(5);
    do_reset();

    // Unlock with the default code, then lock again.
    seq(32'h1234E, 5);
    check_press(14);

    // Two wrong entries, overflow entry into lockout, then a good entry.
    seq(32'h1235E, 5);
    seq(32'h123E, 4);
    seq(32'h12346E, 6);
    seq(32'h1234E, 5);

    // Reprogram to 9876, lock, old code rejected, new code accepted.
    seq(32'hA9876E, 6);
    check_press(15);
    seq(32'h1234E, 5);
    seq(32'h9876E, 5);

    // Auto-relock: unlocked for exactly RELOCK_LEN cycles with no keys.
    check_press(15);
    seq(32'h987, 3);
    check_press(6);
    s_unl = n_unl;
    check_press(14);
    repeat (60) @(negedge clk);
    check("relock_cycles", 32'(n_unl - s_unl), 32'(RELOCK_LEN));
    check("relock_state",  32'(unlocked),      32'd0);
    m_st = M_LOCKED;

    // Cancel mid-entry, then cancel out of PROGRAM keeps the code.
    seq(32'h98F9876E, 8);
    seq(32'hA1F, 3);
    check_press(14);
    seq(32'h9876E, 5);

    // Reset after reprogramming reverts to the default code.
    do_reset();
    seq(32'h1234E, 5);
    check_press(14);

    // Reset in the middle of a lockout.
    seq(32'h5E, 2);
    check_press(14);
    check_press(5);
    press(14, 20, 0);
    check("lockout_active", 32'(alarm), 32'd1);
    do_reset();
    seq(32'h1234E, 5);
    check_press(14);

    // Randomized key sequences.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)       k = m_code[m_q.size() % 4];
      else if (r < 7)  k = 14;
      else if (r == 7) k = 15;
      else if (r == 8) k = 10;
      else             k = int'($urandom_range(0, 15));
      check_press(k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
